// File: rtl/sva_mux_mon.sv
// Multi-channel mux select monitor: checks one-hot encoding and hold stability per channel,
// keeps sticky flags, saturating counts and a first-failure record with a timestamp.
module sva_mux_mon #(
  parameter int N          = 4,
  parameter int CH         = 2,
  parameter bit ALLOW_NULL = 1'b1,
  parameter bit STABLE_CHK = 1'b1,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 16,
  parameter bit SIM_ASSERT = 1'b1,
  localparam int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       i_en,
  input  logic [CH*N-1:0]     i_sel,
  input  logic [CH-1:0]       i_hold,
  input  logic                i_clr,
  output logic [CH-1:0]       o_err,
  output logic                o_err_any,
  output logic [CH*CNT_W-1:0] o_cnt,
  output logic                o_first_vld,
  output logic [CHW-1:0]      o_first_ch,
  output logic [N-1:0]        o_first_sel,
  output logic [1:0]          o_first_kind,
  output logic [TS_W-1:0]     o_first_ts
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CH-1:0][N-1:0]     selV;
  logic [CH-1:0][N-1:0]     pSel_q, pSel_d;
  logic [CH-1:0]            pVld_q, pVld_d;
  logic [CH-1:0]            err_q, err_d;
  logic [CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                     firstVld_q, firstVld_d;
  logic [CHW-1:0]           firstCh_q, firstCh_d;
  logic [N-1:0]             firstSel_q, firstSel_d;
  logic [1:0]               firstKind_q, firstKind_d;
  logic [TS_W-1:0]          tsCnt_q, tsCnt_d;

  logic [CH-1:0]            encViol;
  logic [CH-1:0]            stabViol;
  logic [CH-1:0]            viol;

  assign selV = i_sel;

  // Clearing the lowest set bit leaves zero only for all-zero or one-hot values.
  function automatic logic atMostOne(input logic [N-1:0] s);
    return (s & (s - N'(1))) == '0;
  endfunction

  always_comb begin
    encViol  = '0;
    stabViol = '0;
    for (int c = 0; c < CH; c++) begin
      if (ALLOW_NULL) begin
        encViol[c] = i_en[c] && !atMostOne(selV[c]);
      end else begin
        encViol[c] = i_en[c] && !(atMostOne(selV[c]) && (selV[c] != '0));
      end
      stabViol[c] = STABLE_CHK && i_en[c] && i_hold[c] && pVld_q[c] &&
                    (selV[c] != pSel_q[c]);
    end
  end

  assign viol = encViol | stabViol;

  always_comb begin
    err_d       = err_q;
    cnt_d       = cnt_q;
    firstVld_d  = firstVld_q;
    firstCh_d   = firstCh_q;
    firstSel_d  = firstSel_q;
    firstKind_d = firstKind_q;
    pVld_d      = i_en;
    pSel_d      = pSel_q;
    tsCnt_d     = tsCnt_q + TS_W'(1);

    for (int c = 0; c < CH; c++) begin
      if (i_en[c]) begin
        pSel_d[c] = selV[c];
      end
    end

    if (i_clr) begin
      err_d       = '0;
      cnt_d       = '0;
      firstVld_d  = 1'b0;
      firstCh_d   = '0;
      firstSel_d  = '0;
      firstKind_d = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (viol[c]) begin
          err_d[c] = 1'b1;
          if (cnt_q[c] != CntMax) begin
            cnt_d[c] = cnt_q[c] + CNT_W'(1);
          end
        end
      end
      // Scanning downwards lets the lowest violating channel overwrite last.
      if (!firstVld_q) begin
        for (int c = CH - 1; c >= 0; c--) begin
          if (viol[c]) begin
            firstVld_d  = 1'b1;
            firstCh_d   = CHW'(c);
            firstSel_d  = selV[c];
            firstKind_d = {stabViol[c], encViol[c]};
          end
        end
      end
    end
  end

  logic [TS_W-1:0] firstTs_q, firstTs_d;

  always_comb begin
    firstTs_d = firstTs_q;
    if (i_clr) begin
      firstTs_d = '0;
    end else if (!firstVld_q && (viol != '0)) begin
      firstTs_d = tsCnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pSel_q      <= '0;
      pVld_q      <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      firstVld_q  <= 1'b0;
      firstCh_q   <= '0;
      firstSel_q  <= '0;
      firstKind_q <= '0;
      firstTs_q   <= '0;
      tsCnt_q     <= '0;
    end else begin
      pSel_q      <= pSel_d;
      pVld_q      <= pVld_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      firstVld_q  <= firstVld_d;
      firstCh_q   <= firstCh_d;
      firstSel_q  <= firstSel_d;
      firstKind_q <= firstKind_d;
      firstTs_q   <= firstTs_d;
      tsCnt_q     <= tsCnt_d;
    end
  end

  assign o_err        = err_q;
  assign o_err_any    = |err_q;
  assign o_cnt        = cnt_q;
  assign o_first_vld  = firstVld_q;
  assign o_first_ch   = firstCh_q;
  assign o_first_sel  = firstSel_q;
  assign o_first_kind = firstKind_q;
  assign o_first_ts   = firstTs_q;

`ifndef SYNTHESIS
  generate
    if (SIM_ASSERT) begin : gAssert
      for (genvar c = 0; c < CH; c++) begin : gCh
        always_ff @(posedge clk) begin
          if (!rst) begin
            assert (!viol[c])
              else $error("sva_mux_mon: violation on channel %0d, sel=%b", c, selV[c]);
          end
        end
      end
    end
  endgenerate
`endif

endmodule

// File: tb/tb_sva_mux_mon.sv
// Bench for sva_mux_mon: two instances (onehot0/8-bit counts and strict onehot/3-bit counts)
// share the stimulus and are compared against constant vectors and a behavioural model.
module tb_sva_mux_mon;

  logic        clk;
  logic        rst;
  logic [1:0]  en;
  logic [7:0]  sel;
  logic [1:0]  hold;
  logic        clr;

  logic [1:0]  errA, errB;
  logic        errAnyA, errAnyB;
  logic [15:0] cntA;
  logic [5:0]  cntB;
  logic        fvA, fvB;
  logic [0:0]  fchA, fchB;
  logic [3:0]  fselA, fselB;
  logic [1:0]  fkindA, fkindB;
  logic [15:0] ftsA, ftsB;

  int testsRun = 0;
  int testsFailed = 0;

  sva_mux_mon #(.N(4), .CH(2), .ALLOW_NULL(1'b1), .STABLE_CHK(1'b1), .CNT_W(8),
                .TS_W(16), .SIM_ASSERT(1'b0)) dutA (
    .clk(clk), .rst(rst), .i_en(en), .i_sel(sel), .i_hold(hold), .i_clr(clr),
    .o_err(errA), .o_err_any(errAnyA), .o_cnt(cntA), .o_first_vld(fvA),
    .o_first_ch(fchA), .o_first_sel(fselA), .o_first_kind(fkindA), .o_first_ts(ftsA)
  );

  sva_mux_mon #(.N(4), .CH(2), .ALLOW_NULL(1'b0), .STABLE_CHK(1'b1), .CNT_W(3),
                .TS_W(16), .SIM_ASSERT(1'b0)) dutB (
    .clk(clk), .rst(rst), .i_en(en), .i_sel(sel), .i_hold(hold), .i_clr(clr),
    .o_err(errB), .o_err_any(errAnyB), .o_cnt(cntB), .o_first_vld(fvB),
    .o_first_ch(fchB), .o_first_sel(fselB), .o_first_kind(fkindB), .o_first_ts(ftsB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state; index k: 0 = instance A, 1 = instance B.
  bit mErr[2][2];
  int mCnt[2][2];
  bit mFv[2];
  int mFch[2], mFsel[2], mFkind[2], mFts[2];
  int mPsel[2];
  bit mPv[2];
  int mTs;

  task automatic clearReport(input int k);
    for (int c = 0; c < 2; c++) begin
      mErr[k][c] = 1'b0;
      mCnt[k][c] = 0;
    end
    mFv[k] = 1'b0;
    mFch[k] = 0;
    mFsel[k] = 0;
    mFkind[k] = 0;
    mFts[k] = 0;
  endtask

  task automatic modelEdge();
    int s, ones, cmax;
    bit enc, stab;
    if (rst) begin
      clearReport(0);
      clearReport(1);
      for (int c = 0; c < 2; c++) begin
        mPsel[c] = 0;
        mPv[c] = 1'b0;
      end
      mTs = 0;
      return;
    end
    for (int k = 0; k < 2; k++) begin
      cmax = (k == 0) ? 255 : 7;
      if (clr) begin
        clearReport(k);
      end else begin
        for (int c = 0; c < 2; c++) begin
          s = int'(sel[c*4 +: 4]);
          ones = $countones(sel[c*4 +: 4]);
          enc = en[c] && ((k == 0) ? (ones > 1) : (ones != 1));
          stab = en[c] && hold[c] && mPv[c] && (s != mPsel[c]);
          if (enc || stab) begin
            mErr[k][c] = 1'b1;
            if (mCnt[k][c] < cmax) mCnt[k][c]++;
            if (!mFv[k]) begin
              mFv[k] = 1'b1;
              mFch[k] = c;
              mFsel[k] = s;
              mFkind[k] = (stab ? 2 : 0) + (enc ? 1 : 0);
              mFts[k] = mTs;
            end
          end
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (en[c]) mPsel[c] = int'(sel[c*4 +: 4]);
      mPv[c] = en[c];
    end
    mTs = (mTs + 1) % 65536;
  endtask

  function automatic logic [23:0] packFirst(input bit fv, input int ch, input int s,
                                            input int kind, input int ts);
    return {fv, 1'(ch), 4'(s), 2'(kind), 16'(ts)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] e, input logic [7:0] s,
                               input logic [1:0] h, input logic c);
    en = e;
    sel = s;
    hold = h;
    clr = c;
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    logic [1:0]  eErrA, eErrB;
    logic [15:0] eCntA;
    logic [5:0]  eCntB;
    eErrA = {mErr[0][1], mErr[0][0]};
    eErrB = {mErr[1][1], mErr[1][0]};
    eCntA = {8'(mCnt[0][1]), 8'(mCnt[0][0])};
    eCntB = {3'(mCnt[1][1]), 3'(mCnt[1][0])};
    checkOutput({tag, "/A.err"}, 32'(errA), 32'(eErrA));
    checkOutput({tag, "/A.errAny"}, 32'(errAnyA), 32'(|eErrA));
    checkOutput({tag, "/A.cnt"}, 32'(cntA), 32'(eCntA));
    checkOutput({tag, "/A.first"}, 32'({fvA, fchA, fselA, fkindA, ftsA}),
                32'(packFirst(mFv[0], mFch[0], mFsel[0], mFkind[0], mFts[0])));
    checkOutput({tag, "/B.err"}, 32'(errB), 32'(eErrB));
    checkOutput({tag, "/B.errAny"}, 32'(errAnyB), 32'(|eErrB));
    checkOutput({tag, "/B.cnt"}, 32'(cntB), 32'(eCntB));
    checkOutput({tag, "/B.first"}, 32'({fvB, fchB, fselB, fkindB, ftsB}),
                32'(packFirst(mFv[1], mFch[1], mFsel[1], mFkind[1], mFts[1])));
  endtask

  typedef struct {
    logic [1:0]  en;
    logic [7:0]  sel;
    logic [1:0]  hold;
    logic        clr;
    logic [1:0]  errA;
    logic [15:0] cntA;
    logic [23:0] firstA;
    logic [1:0]  errB;
    logic [5:0]  cntB;
    logic [23:0] firstB;
  } vec_t;

  vec_t vecs[9];
  int   sweep[5];
  logic [7:0] lastSel;
  int   tsStart;

  initial begin
    rst = 1'b1;
    en = '0;
    sel = '0;
    hold = '0;
    clr = 1'b0;
    lastSel = '0;

    // Cycle i of the table runs at ts == i after reset.
    vecs[0] = '{2'b11, 8'h11, 2'b00, 1'b0, 2'b00, 16'h0, 24'h0, 2'b00, 6'o00, 24'h0};
    vecs[1] = '{2'b11, 8'h22, 2'b00, 1'b0, 2'b00, 16'h0, 24'h0, 2'b00, 6'o00, 24'h0};
    vecs[2] = '{2'b11, 8'h44, 2'b00, 1'b0, 2'b00, 16'h0, 24'h0, 2'b00, 6'o00, 24'h0};
    vecs[3] = '{2'b11, 8'h88, 2'b00, 1'b0, 2'b00, 16'h0, 24'h0, 2'b00, 6'o00, 24'h0};
    vecs[4] = '{2'b01, 8'hF8, 2'b11, 1'b0, 2'b00, 16'h0, 24'h0, 2'b00, 6'o00, 24'h0};
    vecs[5] = '{2'b11, 8'h08, 2'b10, 1'b0, 2'b00, 16'h0, 24'h0,
                2'b10, 6'o10, packFirst(1'b1, 1, 0, 1, 5)};
    vecs[6] = '{2'b11, 8'h01, 2'b01, 1'b0, 2'b01, 16'h0001, packFirst(1'b1, 0, 1, 2, 6),
                2'b11, 6'o21, packFirst(1'b1, 1, 0, 1, 5)};
    vecs[7] = '{2'b11, 8'h1C, 2'b00, 1'b1, 2'b00, 16'h0, 24'h0, 2'b00, 6'o00, 24'h0};
    vecs[8] = '{2'b11, 8'h11, 2'b11, 1'b0, 2'b01, 16'h0001, packFirst(1'b1, 0, 1, 2, 8),
                2'b01, 6'o01, packFirst(1'b1, 0, 1, 2, 8)};
    sweep = '{0, 1, 2, 4, 8};

    applyStimulus(2'b11, 8'h3C, 2'b11, 1'b0);
    applyStimulus(2'b11, 8'h3C, 2'b11, 1'b0);
    checkOutput("reset/A.err", 32'(errA), 32'h0);
    checkOutput("reset/A.cnt", 32'(cntA), 32'h0);
    checkOutput("reset/A.first", 32'({fvA, fchA, fselA, fkindA, ftsA}), 32'h0);
    checkOutput("reset/B.errAny", 32'(errAnyB), 32'h0);
    checkModel("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].en, vecs[i].sel, vecs[i].hold, vecs[i].clr);
      checkOutput($sformatf("vec%0d/A.err", i), 32'(errA), 32'(vecs[i].errA));
      checkOutput($sformatf("vec%0d/A.cnt", i), 32'(cntA), 32'(vecs[i].cntA));
      checkOutput($sformatf("vec%0d/A.first", i),
                  32'({fvA, fchA, fselA, fkindA, ftsA}), 32'(vecs[i].firstA));
      checkOutput($sformatf("vec%0d/B.err", i), 32'(errB), 32'(vecs[i].errB));
      checkOutput($sformatf("vec%0d/B.cnt", i), 32'(cntB), 32'(vecs[i].cntB));
      checkOutput($sformatf("vec%0d/B.first", i),
                  32'({fvB, fchB, fselB, fkindB, ftsB}), 32'(vecs[i].firstB));
    end

    // Legal sweep for the onehot0 instance.
    applyStimulus(2'b00, 8'h00, 2'b00, 1'b1);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(2'b11, {4'(sweep[(i + 2) % 5]), 4'(sweep[i % 5])}, 2'b00, 1'b0);
      checkOutput("sweep/A.err", 32'(errA), 32'h0);
      checkOutput("sweep/A.cnt", 32'(cntA), 32'h0);
      checkOutput("sweep/A.fv", 32'(fvA), 32'h0);
      checkModel("sweep");
    end

    for (int i = 0; i < 300; i++) begin
      logic [1:0] e, h;
      logic [7:0] s;
      logic [3:0] v;
      logic c;
      rst = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b11;
      h = 2'($urandom());
      c = ($urandom_range(0, 19) == 0);
      s = '0;
      for (int ch = 0; ch < 2; ch++) begin
        case ($urandom_range(0, 3))
          0: v = 4'($urandom());
          1: v = 4'b0000;
          default: v = 4'b0001 << $urandom_range(0, 3);
        endcase
        if (h[ch] && ($urandom_range(0, 1) == 1)) v = lastSel[ch*4 +: 4];
        s[ch*4 +: 4] = v;
      end
      lastSel = s;
      applyStimulus(e, s, h, c);
      checkModel($sformatf("rand%0d", i));
    end
    rst = 1'b0;

    // Saturation: strict instance stops at 7, wide instance keeps counting.
    applyStimulus(2'b00, 8'h00, 2'b00, 1'b1);
    tsStart = mTs;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b01, 8'h0C, 2'b00, 1'b0);
      checkModel("sat");
    end
    checkOutput("sat/B.cnt0", 32'(cntB[2:0]), 32'd7);
    checkOutput("sat/A.cnt0", 32'(cntA[7:0]), 32'd10);
    checkOutput("sat/B.first", 32'({fvB, fchB, fselB, fkindB, ftsB}),
                32'(packFirst(1'b1, 0, 12, 1, tsStart)));

    // Reset mid-run, then no hold reference on the first enabled cycle.
    rst = 1'b1;
    applyStimulus(2'b11, 8'h3C, 2'b11, 1'b0);
    rst = 1'b0;
    checkOutput("midrst/A.err", 32'(errA), 32'h0);
    checkOutput("midrst/B.cnt", 32'(cntB), 32'h0);
    checkOutput("midrst/A.first", 32'({fvA, fchA, fselA, fkindA, ftsA}), 32'h0);
    applyStimulus(2'b11, 8'h42, 2'b11, 1'b0);
    checkOutput("midrst/hold.A.err", 32'(errA), 32'h0);
    checkOutput("midrst/hold.B.err", 32'(errB), 32'h0);
    applyStimulus(2'b11, 8'h43, 2'b11, 1'b0);
    checkOutput("midrst/both.A.first", 32'({fvA, fchA, fselA, fkindA, ftsA}),
                32'(packFirst(1'b1, 0, 3, 3, 1)));
    checkOutput("midrst/both.A.cnt", 32'(cntA), 32'h0001);
    checkModel("midrst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sva_mux_mon.md
# sva_mux_mon

Multi-channel, clocked monitor for mux select vectors, synthesizable so it can sit in emulation and FPGA builds as well as simulation. For each of CH channels it checks every enabled cycle that the N-bit select is one-hot, or one-hot-or-null, and optionally that the select holds stable across a hold window. Violations are reported through per-channel sticky flags and saturating counters. The first failure is captured with its channel, select value, kind and timestamp. It instantiates next to datapath muxes and is read by the bench or a debug CSR block.

## Interface
- N, default 4: select width per channel (>= 2)
- CH, default 2: number of monitored channels (>= 1)
- ALLOW_NULL, default 1: 1 = all-zero select legal (onehot0); 0 = exactly one bit required
- STABLE_CHK, default 1: 1 = hold-stability check enabled; 0 = i_hold ignored
- CNT_W, default 8: per-channel violation counter width
- TS_W, default 16: timestamp counter width
- SIM_ASSERT, default 1: emit simulation-only immediate assertions on each violation
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- i_en  in  CH  per-channel check enable
- i_sel  in  CH*N  channel c select at [c*N +: N]
- i_hold  in  CH  channel c select must equal its previous-cycle value
- i_clr  in  1  clear all reporting state
- o_err  out  CH  per-channel sticky error
- o_err_any  out  1  OR of o_err
- o_cnt  out  CH*CNT_W  channel c saturating violation count at [c*CNT_W +: CNT_W]
- o_first_vld  out  1  first-failure record valid
- o_first_ch  out  max(1,$clog2(CH))  channel of first failure
- o_first_sel  out  N  offending select value
- o_first_kind  out  2  bit0 = encoding violation, bit1 = stability violation
- o_first_ts  out  TS_W  timestamp of first failure

## Operation
- Encoding violation, channel c: i_en[c] && !(ALLOW_NULL ? $onehot0(sel) : $onehot(sel)).
- Stability violation: STABLE_CHK && i_en[c] && i_hold[c] && p_vld[c] && (sel != p_sel[c]).
- p_sel[c] and p_vld[c] are internal registers. p_sel[c] <= sel when i_en[c]; p_vld[c] <= i_en[c]. The first enabled cycle after a gap has no stability reference.
- viol[c] = encoding | stability violation. A cycle with both kinds counts once.
- On viol[c], o_err[c] sets and o_cnt[c] increments, saturating at 2^CNT_W-1 with no wrap.
- First-failure capture happens only while o_first_vld=0.
  - The lowest-index violating channel wins.
  - Records channel, sel, kind bits and the current ts value; o_first_vld sets.
  - Later failures do not overwrite the record until it is cleared.
- ts is a free-running counter incremented every cycle and wrapping modulo 2^TS_W. It is 0 in the first cycle after reset deasserts. It is not affected by i_clr.
- i_clr clears o_err, o_cnt, the first-failure record and o_first_vld.
  - Violations in the same cycle as i_clr are discarded.
  - i_clr does not touch p_sel, p_vld or ts.
- When SIM_ASSERT=1, an immediate assertion fires per violating channel with channel and sel in the message. It is excluded under SYNTHESIS.

## Timing
- Reset: every output 0; p_vld=0, p_sel=0, ts=0.
- Reset mid-operation drops all state in one cycle; inputs in the reset cycle are ignored.
- Latency: inputs sampled at edge t appear on o_err, o_cnt and o_first_* after edge t, i.e. visible in cycle t+1.
- o_err_any is combinational from o_err, with the same one-cycle latency.
- i_clr in cycle t: all reporting outputs read 0 in t+1. A violation in t+1 is recorded normally in t+2.
- Disabled channels (i_en=0) never flag, whatever i_sel or i_hold are.

## Test plan
- Legal traffic: N=4, CH=2, ALLOW_NULL=1; sel sweeps 0,1,2,4,8 on both channels for 50 cycles -> o_err=0, o_cnt=0, o_first_vld=0.
- Encoding fault: ALLOW_NULL=0, ch1 sel=4'b0000 at ts=5 -> in cycle 6: o_err=2'b10, ch1 cnt=1, first_ch=1, first_sel=0, first_kind=2'b01, first_ts=5.
- Stability and priority: ch0 sel 4'b0001 then 4'b0010 with i_hold=1, and ch1 sel=4'b0011 in the same cycle -> first_ch=0, first_kind=2'b10; both o_err bits set; second record not captured.
- Saturation: CNT_W=3, ch0 sel=4'b1100 for 10 cycles -> o_cnt[0] reaches 7 and stays 7; first record holds cycle 1 values.
- Clear collision: violation and i_clr in the same cycle -> all outputs 0 next cycle; violation the following cycle -> cnt=1, new first record with the correct ts.
- Reset mid-run: rst after errors logged -> all outputs 0 next cycle, ts restarts at 0; hold check does not fire on the first enabled cycle after reset.
